// File: rtl/rom_load_ctrl.sv
// ROM download controller: decodes HPS ioctl bytes into ROM region writes, captures DIP bytes,
// and sequences core reset. States: WAIT_ROM idle | LOADING bytes | DRAIN finish buffer | HOLD count | RUN.
module rom_load_ctrl #(
  parameter int unsigned RST_HOLD  = 16,
  parameter logic [7:0]  DIP_INDEX = 8'd254
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [3:0]  rom_cs,
  output logic [14:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        rom_we,
  input  logic        rom_ack,
  output logic [23:0] dip_sw,
  output logic        core_reset,
  output logic        load_done,
  output logic        wr_err
);

  typedef enum logic [2:0] {WAIT_ROM, LOADING, DRAIN, HOLD, RUN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic        load_done_q, load_done_d;
  logic        rom_we_q, rom_we_d;
  logic [3:0]  rom_cs_q, rom_cs_d;
  logic [14:0] rom_addr_q, rom_addr_d;
  logic [7:0]  rom_data_q, rom_data_d;
  logic        wr_err_q, wr_err_d;
  logic [23:0] dip_q, dip_d;
  logic        dl_q;

  logic        map_hit;
  logic [3:0]  map_cs;
  logic [14:0] map_off;
  logic        rom_stb, buf_free, accept, dip_stb, rom_start;

  always_comb begin
    map_hit = 1'b1;
    map_cs  = 4'b0000;
    map_off = 15'd0;
    if (ioctl_addr < 25'h08000) begin
      map_cs  = 4'b0001;
      map_off = ioctl_addr[14:0];
    end else if (ioctl_addr < 25'h0A000) begin
      map_cs  = 4'b0010;
      map_off = 15'(ioctl_addr - 25'h08000);
    end else if (ioctl_addr < 25'h0E000) begin
      map_cs  = 4'b0100;
      map_off = 15'(ioctl_addr - 25'h0A000);
    end else if (ioctl_addr < 25'h0E100) begin
      map_cs  = 4'b1000;
      map_off = 15'(ioctl_addr - 25'h0E000);
    end else begin
      map_hit = 1'b0;
    end
  end

  // A download is only recognised on a 0->1 edge of ioctl_download, so one
  // that was already running across a reset stays ignored.
  assign rom_start = ioctl_download & ~dl_q & (ioctl_index == 8'd0);
  assign rom_stb   = ioctl_download & ioctl_wr & (ioctl_index == 8'd0) &
                     (state_q == LOADING) & map_hit;
  assign buf_free  = ~rom_we_q | rom_ack;
  assign accept    = rom_stb & buf_free;
  assign dip_stb   = ioctl_download & ioctl_wr & (ioctl_index == DIP_INDEX) &
                     (ioctl_addr < 25'd3);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    load_done_d = load_done_q;
    case (state_q)
      WAIT_ROM: if (rom_start) state_d = LOADING;
      LOADING:  if (!ioctl_download) state_d = DRAIN;
      DRAIN: begin
        if (rom_start) begin
          state_d = LOADING;
        end else if (!rom_we_q) begin
          hold_d  = 8'(RST_HOLD);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (rom_start) begin
          state_d = LOADING;
        end else begin
          hold_d = hold_q - 8'd1;
          if (hold_q == 8'd1) begin
            state_d     = RUN;
            load_done_d = 1'b1;
          end
        end
      end
      RUN:      if (rom_start) state_d = LOADING;
      default:  state_d = WAIT_ROM;
    endcase
  end

  always_comb begin
    rom_we_d   = rom_we_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
    wr_err_d   = wr_err_q | (rom_stb & ~buf_free);
    dip_d      = dip_q;
    if (accept) begin
      rom_we_d   = 1'b1;
      rom_cs_d   = map_cs;
      rom_addr_d = map_off;
      rom_data_d = ioctl_dout;
    end else if (rom_we_q && rom_ack) begin
      rom_we_d = 1'b0;
      rom_cs_d = 4'b0000;
    end
    if (dip_stb) begin
      case (ioctl_addr[1:0])
        2'd0:    dip_d[7:0]   = ioctl_dout;
        2'd1:    dip_d[15:8]  = ioctl_dout;
        default: dip_d[23:16] = ioctl_dout;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q     <= WAIT_ROM;
      hold_q      <= 8'd0;
      load_done_q <= 1'b0;
      rom_we_q    <= 1'b0;
      rom_cs_q    <= 4'b0000;
      rom_addr_q  <= 15'd0;
      rom_data_q  <= 8'd0;
      wr_err_q    <= 1'b0;
      dip_q       <= 24'h000000;
      dl_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      load_done_q <= load_done_d;
      rom_we_q    <= rom_we_d;
      rom_cs_q    <= rom_cs_d;
      rom_addr_q  <= rom_addr_d;
      rom_data_q  <= rom_data_d;
      wr_err_q    <= wr_err_d;
      dip_q       <= dip_d;
      dl_q        <= ioctl_download;
    end
  end

  assign ioctl_wait = rom_we_q;
  assign rom_we     = rom_we_q;
  assign rom_cs     = rom_cs_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign wr_err     = wr_err_q;
  assign dip_sw     = dip_q;
  assign load_done  = load_done_q;
  assign core_reset = (state_q != RUN);

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Self-checking bench for rom_load_ctrl: directed map/stall/release/DIP/reload/reset
// sequences, then randomized ROM/DIP traffic against a queue-based reference model.
module tb_rom_load_ctrl;
  localparam int unsigned RST_HOLD  = 16;
  localparam logic [7:0]  DIP_INDEX = 8'd254;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [3:0]  rom_cs;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_we;
  logic        rom_ack;
  logic [23:0] dip_sw;
  logic        core_reset;
  logic        load_done;
  logic        wr_err;

  rom_load_ctrl #(.RST_HOLD(RST_HOLD), .DIP_INDEX(DIP_INDEX)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .rom_cs(rom_cs),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_we(rom_we), .rom_ack(rom_ack),
    .dip_sw(dip_sw), .core_reset(core_reset), .load_done(load_done), .wr_err(wr_err)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, "_rom_we"},     32'(rom_we),     32'd0);
    chk({tag, "_rom_cs"},     32'(rom_cs),     32'd0);
    chk({tag, "_rom_addr"},   32'(rom_addr),   32'd0);
    chk({tag, "_rom_data"},   32'(rom_data),   32'd0);
    chk({tag, "_ioctl_wait"}, 32'(ioctl_wait), 32'd0);
    chk({tag, "_load_done"},  32'(load_done),  32'd0);
    chk({tag, "_wr_err"},     32'(wr_err),     32'd0);
    chk({tag, "_dip_sw"},     32'(dip_sw),     32'd0);
  endtask

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic        we;
    logic [3:0]  cs;
    logic [14:0] off;
  } map_vec_t;
  map_vec_t mv[11];

  // reference model: region table and a one-deep write buffer queue
  typedef struct {
    logic [3:0]  cs;
    logic [14:0] off;
    logic [7:0]  data;
  } wr_t;
  wr_t         bufq[$];
  int unsigned reg_base[4] = '{32'h0000, 32'h8000, 32'hA000, 32'hE000};
  int unsigned reg_size[4] = '{32'h8000, 32'h2000, 32'h4000, 32'h0100};
  logic [7:0]  m_dip[3];
  logic        m_err;
  logic [24:0] bl[10];

  function automatic logic decode(input int unsigned a, output logic [3:0] cs, output logic [14:0] off);
    cs  = 4'b0000;
    off = 15'd0;
    for (int r = 0; r < 4; r++)
      if (a >= reg_base[r] && a < reg_base[r] + reg_size[r]) begin
        cs  = 4'(1 << r);
        off = 15'(a - reg_base[r]);
        return 1'b1;
      end
    return 1'b0;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    logic seen;
    mv[0]  = '{25'h0007FFF, 8'h11, 1'b1, 4'b0001, 15'h7FFF};
    mv[1]  = '{25'h0008000, 8'h22, 1'b1, 4'b0010, 15'h0000};
    mv[2]  = '{25'h000A001, 8'h33, 1'b1, 4'b0100, 15'h0001};
    mv[3]  = '{25'h000E0FF, 8'h44, 1'b1, 4'b1000, 15'h00FF};
    mv[4]  = '{25'h000E100, 8'h55, 1'b0, 4'b0000, 15'h0000};
    mv[5]  = '{25'h0000000, 8'h66, 1'b1, 4'b0001, 15'h0000};
    mv[6]  = '{25'h0009FFF, 8'h77, 1'b1, 4'b0010, 15'h1FFF};
    mv[7]  = '{25'h000DFFF, 8'h88, 1'b1, 4'b0100, 15'h3FFF};
    mv[8]  = '{25'h000E000, 8'h99, 1'b1, 4'b1000, 15'h0000};
    mv[9]  = '{25'h0010000, 8'hAA, 1'b0, 4'b0000, 15'h0000};
    mv[10] = '{25'h1FFFFFF, 8'hBB, 1'b0, 4'b0000, 15'h0000};
    bl = '{25'h0, 25'h7FFF, 25'h8000, 25'h9FFF, 25'hA000, 25'hDFFF,
           25'hE000, 25'hE0FF, 25'hE100, 25'h1FFFFFF};

    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = 25'd0; ioctl_dout = 8'd0; rom_ack = 1'b1;
    cyc(); cyc();
    chk_reset_vals("reset");

    reset_n = 1'b1;
    cyc();
    ioctl_download = 1'b1;
    cyc();
    chk("loading_core_reset", 32'(core_reset), 32'd1);
    chk("loading_load_done", 32'(load_done), 32'd0);

    for (int i = 0; i < 11; i++) begin
      ioctl_addr = mv[i].addr; ioctl_dout = mv[i].data; ioctl_wr = 1'b1;
      cyc();
      ioctl_wr = 1'b0;
      chk($sformatf("map%0d_we", i), 32'(rom_we), 32'(mv[i].we));
      chk($sformatf("map%0d_wait", i), 32'(ioctl_wait), 32'(mv[i].we));
      chk($sformatf("map%0d_cs", i), 32'(rom_cs), 32'(mv[i].cs));
      if (mv[i].we) begin
        chk($sformatf("map%0d_addr", i), 32'(rom_addr), 32'(mv[i].off));
        chk($sformatf("map%0d_data", i), 32'(rom_data), 32'(mv[i].data));
      end
      cyc();
      chk($sformatf("map%0d_we_drop", i), 32'(rom_we), 32'd0);
      chk($sformatf("map%0d_cs_drop", i), 32'(rom_cs), 32'd0);
    end
    chk("map_wr_err", 32'(wr_err), 32'd0);

    // back-to-back acceptance in the ack cycle
    rom_ack = 1'b0; ioctl_addr = 25'h100; ioctl_dout = 8'h5C; ioctl_wr = 1'b1;
    cyc();
    ioctl_wr = 1'b0;
    chk("b2b_first_addr", 32'(rom_addr), 32'h100);
    cyc();
    rom_ack = 1'b1; ioctl_addr = 25'hA050; ioctl_dout = 8'hD2; ioctl_wr = 1'b1;
    chk("b2b_wait_in_ack", 32'(ioctl_wait), 32'd1);
    cyc();
    ioctl_wr = 1'b0;
    chk("b2b_we", 32'(rom_we), 32'd1);
    chk("b2b_cs", 32'(rom_cs), 32'b0100);
    chk("b2b_addr", 32'(rom_addr), 32'h50);
    chk("b2b_data", 32'(rom_data), 32'hD2);
    chk("b2b_wr_err", 32'(wr_err), 32'd0);
    cyc();
    chk("b2b_we_drop", 32'(rom_we), 32'd0);

    // stall: ack low for 5 cycles, a second strobe during the stall is dropped
    rom_ack = 1'b0; ioctl_addr = 25'h10; ioctl_dout = 8'h3C; ioctl_wr = 1'b1;
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_wait", k), 32'(ioctl_wait), 32'd1);
      chk($sformatf("stall%0d_we", k), 32'(rom_we), 32'd1);
      chk($sformatf("stall%0d_addr", k), 32'(rom_addr), 32'h10);
      chk($sformatf("stall%0d_data", k), 32'(rom_data), 32'h3C);
      ioctl_wr = (k == 2); ioctl_addr = 25'h20; ioctl_dout = 8'h99;
      cyc();
    end
    ioctl_wr = 1'b0;
    chk("stall_wr_err", 32'(wr_err), 32'd1);
    rom_ack = 1'b1;
    chk("stall_ack_wait", 32'(ioctl_wait), 32'd1);
    chk("stall_ack_we", 32'(rom_we), 32'd1);
    cyc();
    chk("stall_after_wait", 32'(ioctl_wait), 32'd0);
    chk("stall_after_we", 32'(rom_we), 32'd0);
    chk("stall_after_cs", 32'(rom_cs), 32'd0);

    // release with buffer empty: 1 DRAIN + RST_HOLD HOLD + 1
    ioctl_download = 1'b0;
    rel = -1; seen = 1'b0;
    for (int k = 1; k <= 100 && rel < 0; k++) begin
      cyc();
      if (!core_reset) rel = k;
      else seen = seen | load_done;
    end
    chk("release_cycles", 32'(rel), 32'(RST_HOLD + 2));
    chk("release_load_done", 32'(load_done), 32'd1);
    chk("release_done_early", 32'(seen), 32'd0);

    // DIP bytes in RUN
    ioctl_download = 1'b1; ioctl_index = DIP_INDEX; ioctl_wr = 1'b1;
    ioctl_addr = 25'd0; ioctl_dout = 8'h5A;
    cyc();
    chk("dip_byte0_next", 32'(dip_sw), 32'h00005A);
    chk("dip0_core_reset", 32'(core_reset), 32'd0);
    ioctl_addr = 25'd2; ioctl_dout = 8'hC3;
    cyc();
    chk("dip2_core_reset", 32'(core_reset), 32'd0);
    ioctl_addr = 25'd3; ioctl_dout = 8'hFF;
    cyc();
    chk("dip3_core_reset", 32'(core_reset), 32'd0);
    ioctl_wr = 1'b0;
    cyc();
    chk("dip_value", 32'(dip_sw), 32'hC3005A);
    chk("dip_wait", 32'(ioctl_wait), 32'd0);
    ioctl_download = 1'b0; ioctl_index = 8'd0;
    cyc();
    chk("dip_end_core_reset", 32'(core_reset), 32'd0);

    // reload from RUN, download ends with a byte stuck 3 extra cycles
    ioctl_download = 1'b1;
    cyc();
    chk("reload_core_reset", 32'(core_reset), 32'd1);
    chk("reload_load_done", 32'(load_done), 32'd1);
    rom_ack = 1'b0; ioctl_addr = 25'h1234; ioctl_dout = 8'h77; ioctl_wr = 1'b1;
    cyc();
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    rel = -1; seen = 1'b0;
    for (int k = 1; k <= 100 && rel < 0; k++) begin
      cyc();
      if (k == 3) rom_ack = 1'b1;
      seen = seen | ~load_done;
      if (!core_reset) rel = k;
    end
    chk("reload_release_cycles", 32'(rel), 32'(1 + 3 + RST_HOLD + 1));
    chk("reload_done_held", 32'(seen), 32'd0);

    // reset while a byte is buffered
    ioctl_download = 1'b1;
    cyc();
    rom_ack = 1'b0; ioctl_addr = 25'h42; ioctl_dout = 8'hE7; ioctl_wr = 1'b1;
    cyc();
    ioctl_wr = 1'b0;
    chk("midload_we_before", 32'(rom_we), 32'd1);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1; rom_ack = 1'b1;
    chk_reset_vals("midreset");
    ioctl_wr = 1'b1; ioctl_addr = 25'h55;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("postreset%0d_we", k), 32'(rom_we), 32'd0);
      chk($sformatf("postreset%0d_core_reset", k), 32'(core_reset), 32'd1);
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    cyc();
    ioctl_download = 1'b1;
    cyc();

    // randomized traffic against the model
    m_err = 1'b0;
    for (int j = 0; j < 3; j++) m_dip[j] = 8'h00;
    bufq.delete();
    for (int t = 0; t < 400; t++) begin
      logic [3:0]  c;
      logic [14:0] o;
      logic        hit, done;
      int          sel;
      chk("rnd_we", 32'(rom_we), 32'(bufq.size() != 0));
      chk("rnd_wait", 32'(ioctl_wait), 32'(bufq.size() != 0));
      chk("rnd_cs", 32'(rom_cs), (bufq.size() != 0) ? 32'(bufq[0].cs) : 32'd0);
      if (bufq.size() != 0) begin
        chk("rnd_addr", 32'(rom_addr), 32'(bufq[0].off));
        chk("rnd_data", 32'(rom_data), 32'(bufq[0].data));
      end
      chk("rnd_wr_err", 32'(wr_err), 32'(m_err));
      chk("rnd_dip", 32'(dip_sw), 32'({m_dip[2], m_dip[1], m_dip[0]}));
      chk("rnd_core_reset", 32'(core_reset), 32'd1);

      ioctl_wr   = 1'($urandom_range(0, 1));
      rom_ack    = ($urandom_range(0, 9) < 6);
      ioctl_dout = 8'($urandom);
      sel = int'($urandom_range(0, 9));
      ioctl_index = (sel < 7) ? 8'd0 : (sel < 9) ? DIP_INDEX : 8'd5;
      if (ioctl_index == DIP_INDEX) ioctl_addr = 25'($urandom_range(0, 4));
      else if ($urandom_range(0, 1) == 0) ioctl_addr = bl[$urandom_range(0, 9)];
      else ioctl_addr = 25'($urandom_range(0, 32'h10000));

      done = (bufq.size() != 0) && rom_ack;
      hit  = decode(int'(ioctl_addr), c, o);
      if (done) void'(bufq.pop_front());
      if (ioctl_wr && ioctl_index == 8'd0 && hit) begin
        if (bufq.size() == 0) bufq.push_back('{c, o, ioctl_dout});
        else m_err = 1'b1;
      end
      if (ioctl_wr && ioctl_index == DIP_INDEX && ioctl_addr < 25'd3)
        m_dip[ioctl_addr[1:0]] = ioctl_dout;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
